saph_ch_uninterp: RTL and testbench

- Inverse of the colour channel interpolator.
- Given endpoint channel values `from` and `to` plus a target `value`, finds the coefficient `coeff` such that forward interpolation of (from, to, coeff) lands on `value`.
- Sits beside the blend/gradient path, for gradient setup and colour-key fitting.
- Multi-cycle: valid/ready handshake on both sides and a bit-serial restoring divider.

---
 rtl/saph_ch_uninterp_pkg.sv | 12 +
 rtl/saph_udiv_seq.sv | 77 +++++++
 rtl/saph_ch_uninterp.sv | 134 +++++++++++++
 tb/tb_saph_ch_uninterp.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/saph_ch_uninterp_pkg.sv
// Shared definitions for the channel un-interpolator: FSM state type and default width.
package saph_pkg;

  localparam int SAPH_CH_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } saph_uninterp_state_t;

endpackage

// File: rtl/saph_udiv_seq.sv
// Generic bit-serial restoring divider, MSB-first, one quotient bit per cycle.
// The upper DVS_W bits of the dividend must be smaller than the divisor so the quotient fits Q_W bits.
module saph_udiv_seq #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8,
  parameter int Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);

  localparam int CNT_W = $clog2(Q_W + 1);

  logic [DVS_W:0]   rem_q, rem_d;
  logic [Q_W-1:0]   low_q, low_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DVS_W:0]   trial_s;
  logic             fits_s;
  logic [Q_W-1:0]   low_next_s;

  // Low register shifts dividend bits out at the top and quotient bits in at the bottom.
  always_comb begin
    trial_s    = {rem_q[DVS_W-1:0], low_q[Q_W-1]};
    fits_s     = (trial_s >= {1'b0, dvs_q});
    low_next_s = {low_q[Q_W-2:0], fits_s};
    rem_d      = rem_q;
    low_d      = low_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    if (busy_q) begin
      rem_d  = fits_s ? (trial_s - {1'b0, dvs_q}) : trial_s;
      low_d  = low_next_s;
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = (cnt_q != CNT_W'(1));
    end else if (start_i) begin
      rem_d  = {1'b0, dividend_i[DVD_W-1:Q_W]};
      low_d  = dividend_i[Q_W-1:0];
      dvs_d  = divisor_i;
      cnt_d  = CNT_W'(Q_W);
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= {(DVS_W+1){1'b0}};
      low_q  <= {Q_W{1'b0}};
      dvs_q  <= {DVS_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      low_q  <= low_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Done fires during the final iteration; quotient_o then already includes the last bit.
  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CNT_W'(1));
  assign quotient_o = low_next_s;

endmodule

// File: rtl/saph_ch_uninterp.sv
// Inverse channel interpolator: finds coeff so that lerp(from, to, coeff) lands on value.
// Define SAPH_CH_UNINTERP_ROUND_EN for round-to-nearest division; default build truncates.
module saph_ch_uninterp
  import saph_pkg::*;
#(
  parameter int CH_W = SAPH_CH_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] from,
  input  logic [CH_W-1:0] to,
  input  logic [CH_W-1:0] value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] coeff
);

  saph_uninterp_state_t state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [CH_W-1:0]      coeff_q, coeff_d;

  logic [CH_W-1:0]      d_s, n_s;
  logic                 underflow_s;
  logic [2*CH_W-1:0]    dividend_s;
  logic                 div_start_s, div_busy_s, div_done_s;
  logic [CH_W-1:0]      quot_s, mapped_s;

  // Fold descending ranges onto an ascending distance so one divider serves both directions.
  always_comb begin
    if (to >= from) begin
      d_s         = to - from;
      n_s         = value - from;
      underflow_s = (value < from);
    end else begin
      d_s         = from - to;
      n_s         = from - value;
      underflow_s = (value > from);
    end
  end

`ifdef SAPH_CH_UNINTERP_ROUND_EN
  assign dividend_s = {n_s, 1'b0, d_s[CH_W-1:1]};
`else
  assign dividend_s = {n_s, {CH_W{1'b0}}};
`endif

  // Undo the forward interpolator's +coeff[MSB] bias.
  assign mapped_s = quot_s - {{(CH_W-1){1'b0}}, quot_s[CH_W-1]};

  saph_udiv_seq #(
    .DVD_W (2*CH_W),
    .DVS_W (CH_W),
    .Q_W   (CH_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start_s),
    .dividend_i (dividend_s),
    .divisor_i  (d_s),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .quotient_o (quot_s)
  );

  // Handshake FSM with shortcut results resolved in the accept cycle.
  always_comb begin
    state_d     = state_q;
    coeff_d     = coeff_q;
    div_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if ((d_s == {CH_W{1'b0}}) || underflow_s) begin
            state_d = DONE;
            coeff_d = {CH_W{1'b0}};
          end else if (n_s >= d_s) begin
            state_d = DONE;
            coeff_d = {CH_W{1'b1}};
          end else begin
            state_d     = CALC;
            div_start_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (div_done_s) begin
          state_d = DONE;
          coeff_d = mapped_s;
        end else if (div_busy_s) begin
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // FSM and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      coeff_q     <= {CH_W{1'b0}};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      coeff_q     <= coeff_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign coeff     = coeff_q;

endmodule

// File: tb/tb_saph_ch_uninterp.sv
// Scoreboard bench for saph_ch_uninterp: driver pushes expectations, monitor checks outputs.
module tb_saph_ch_uninterp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] from_s = 8'd0, to_s = 8'd0, value_s = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] coeff;

  typedef struct {
    int coeff;
    int lat;
    int acc;
    int f;
    int t;
    int v;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   bp_mode = 0;  // 0 random out_ready, 1 force low, 2 force high

  saph_ch_uninterp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .from      (from_s),
    .to        (to_s),
    .value     (value_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coeff     (coeff)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: coefficient c such that from + (to-from)*c/256 (with MSB bias) hits value.
  function automatic void model(input int f, input int t, input int v,
                                output int c, output int lat);
    int d, n, r;
    bit uf;
    if (t >= f) begin d = t - f; n = v - f; uf = (v < f); end
    else        begin d = f - t; n = f - v; uf = (v > f); end
    if (d == 0 || uf) begin c = 0; lat = 1; end
    else if (n >= d) begin c = 255; lat = 1; end
    else begin
`ifdef SAPH_CH_UNINTERP_ROUND_EN
      r = (n * 256 + d / 2) / d;
`else
      r = (n * 256) / d;
`endif
      c   = (r >= 128) ? r - 1 : r;
      lat = 9;
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  // Issue one request; c_exp < 0 means take the expectation from the model.
  task automatic send(input int f, input int t, input int v,
                      input int c_exp = -1, input int lat_exp = -1);
    exp_t e;
    int mc, ml;
    wait_ready();
    model(f, t, v, mc, ml);
    e.coeff = (c_exp < 0) ? mc : c_exp;
    e.lat   = (lat_exp < 0) ? ml : lat_exp;
    e.acc   = cyc;
    e.f = f; e.t = t; e.v = v;
    from_s = 8'(f); to_s = 8'(t); value_s = 8'(v);
    in_valid = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    from_s = 8'($urandom); to_s = 8'($urandom); value_s = 8'($urandom);
  endtask

  // out_ready driver.
  initial begin
    forever begin
      @(negedge clk);
      if (bp_mode == 1) out_ready = 1'b0;
      else if (bp_mode == 2) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: check each result once, when out_valid first appears.
  initial begin
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (out_valid && !seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          if (coeff != 8'(e.coeff))
            $display("  for from=%0d to=%0d value=%0d", e.f, e.t, e.v);
          chk("coeff", int'(coeff), e.coeff);
          chk("latency", cyc - e.acc, e.lat);
        end
      end else if (!out_valid) begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lo, hi, f, t, v, n, ce, le;
    // Reset state.
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_coeff", int'(coeff), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
`ifdef SAPH_CH_UNINTERP_ROUND_EN
    send(0, 255, 128, 128, 9);
`else
    send(0, 255, 128, 127, 9);
`endif
    send(200, 100, 150, 127, 9);
    send(0, 255, 64, 64, 9);
    send(10, 10, 99, 0, 1);
    send(10, 20, 5, 0, 1);
    send(10, 20, 25, 255, 1);
    send(0, 255, 255, 255, 1);
    send(255, 0, 0, 255, 1);
    send(100, 50, 120, 0, 1);

    // Backpressure in DONE with in_valid ignored throughout CALC and DONE.
    wait_ready();
    @(posedge clk); #1;
    bp_mode = 1;
    model(0, 255, 128, ce, le);
    send(0, 255, 128);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_reached_done", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_coeff", int'(coeff), ce);
      from_s = 8'($urandom); to_s = 8'($urandom); value_s = 8'($urandom);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bp_mode = 2;
    @(posedge clk); #1;
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_release_out_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    bp_mode = 0;

    // Abort a divide with reset during CALC.
    send(0, 255, 100);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 255, 64, 64, 9);

    // Randomized requests, biased so about half take the divide path.
    for (int i = 0; i < 200; i++) begin
      f = $urandom_range(0, 255);
      t = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) begin
        lo = (f < t) ? f : t;
        hi = (f < t) ? t : f;
        v  = lo + $urandom_range(0, hi - lo);
      end else begin
        v = $urandom_range(0, 255);
      end
      send(f, t, v);
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
